// File: rtl/demux_dispatcher_if.sv
// demux_dispatcher_if: producer/consumer bus of the round-robin dispatcher
interface demux_dispatcher_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = $clog2(CHANNELS);
   logic                flush;
   logic                in_valid;
   logic [WIDTH-1:0]    in_data;
   logic                in_ready;
   logic [WIDTH-1:0]    out_data;
   logic [CHANNELS-1:0] out_valid;
   logic [CHANNELS-1:0] out_ready;
   logic [CHANNELS-1:0] channel_enable;
   logic [SEL_W-1:0]    select;
   logic                busy;
   modport master (
      output flush, in_valid, in_data, out_ready, channel_enable,
      input  in_ready, out_data, out_valid, select, busy
   );
   modport slave (
      input  flush, in_valid, in_data, out_ready, channel_enable,
      output in_ready, out_data, out_valid, select, busy
   );
endinterface

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: one-word round-robin fan-out to CHANNELS consumers; channel mask via DEMUX_DISPATCHER_MASK_EN
module demux_dispatcher #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input logic                i_clk,
   input logic                i_rst,
   demux_dispatcher_if.slave  io_bus
);
   localparam int SEL_W = $clog2(CHANNELS);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t              r_state, w_state_nxt;
   logic [WIDTH-1:0]    r_hold, w_hold_nxt;
   logic [SEL_W-1:0]    r_tgt, w_tgt_nxt, r_ptr, w_ptr_nxt, r_select;
   logic [SEL_W-1:0]    w_base, w_choice;
   logic [CHANNELS-1:0] r_out_valid;
   logic                r_busy, w_xfer, w_accept, w_any_en, w_in_ready;
   assign w_xfer     = (r_state == FULL) && io_bus.out_ready[r_tgt] && !io_bus.flush;
   assign w_base     = (r_state == FULL) ? r_tgt + 1'b1 : r_ptr;
   assign w_in_ready = !i_rst && !io_bus.flush && w_any_en && ((r_state == EMPTY) || io_bus.out_ready[r_tgt]);
   assign w_accept   = io_bus.in_valid && w_in_ready;
`ifdef DEMUX_DISPATCHER_MASK_EN
   // first enabled channel at or after the pointer, wrapping modulo CHANNELS
   always_comb begin
      w_choice = w_base;
      w_any_en = |io_bus.channel_enable;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (io_bus.channel_enable[w_base + SEL_W'(i)]) w_choice = w_base + SEL_W'(i);
   end
`else
   assign w_choice = w_base;
   assign w_any_en = 1'b1;
`endif
   // next state: flush clears, transfer frees the slot, accept (possibly same cycle) refills it
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_tgt_nxt   = r_tgt;
      w_hold_nxt  = r_hold;
      if (io_bus.flush) begin
         w_state_nxt = EMPTY;
         w_ptr_nxt   = '0;
      end else begin
         if (w_xfer) begin
            w_state_nxt = EMPTY;
            w_ptr_nxt   = r_tgt + 1'b1;
         end
         if (w_accept) begin
            w_state_nxt = FULL;
            w_hold_nxt  = io_bus.in_data;
            w_tgt_nxt   = w_choice;
         end
      end
   end
   // state and registered outputs, cleared immediately by reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= EMPTY;
         r_hold      <= '0;
         r_tgt       <= '0;
         r_ptr       <= '0;
         r_out_valid <= '0;
         r_select    <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold      <= w_hold_nxt;
         r_tgt       <= w_tgt_nxt;
         r_ptr       <= w_ptr_nxt;
         r_out_valid <= (w_state_nxt == FULL) ? CHANNELS'(1) << w_tgt_nxt : '0;
         r_select    <= (w_state_nxt == FULL) ? w_tgt_nxt : w_ptr_nxt;
         r_busy      <= (w_state_nxt == FULL);
      end
   end
   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_data  = r_hold;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.select    = r_select;
   assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: scoreboard bench for demux_dispatcher (CHANNELS=4, WIDTH=8)
module tb_demux_dispatcher;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   typedef struct {int ch; logic [7:0] d;} exp_t;
   exp_t sb[$];
   int m_ptr = 0;
   demux_dispatcher_if #(.WIDTH(8), .CHANNELS(4)) bus();
   demux_dispatcher #(.WIDTH(8), .CHANNELS(4)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
   always #5 clk = ~clk;
   function automatic int pick(int p, logic [3:0] en);
      int r;
      r = p;
`ifdef DEMUX_DISPATCHER_MASK_EN
      for (int i = 3; i >= 0; i--) if (en[(p + i) % 4]) r = (p + i) % 4;
`else
      if (en === 4'bxxxx) r = p;
`endif
      return r;
   endfunction
   // scoreboard: push on accept, pop and compare on each channel transfer
   always @(negedge clk) begin
      if (rst || bus.flush) begin
         sb.delete();
         m_ptr = 0;
      end else begin
         if (|(bus.out_valid & bus.out_ready)) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: out_valid=%b data=%h, required no transfer", bus.out_valid, bus.out_data);
            end else begin
               exp_t e;
               logic [3:0] oh;
               e = sb.pop_front();
               oh = 4'b0001 << e.ch;
               if (bus.out_valid !== oh || bus.out_data !== e.d) begin
                  n_fail++;
                  $display("FAIL sb_transfer: out_valid=%b data=%h, required %b/%h", bus.out_valid, bus.out_data, oh, e.d);
               end
               m_ptr = (e.ch + 1) % 4;
            end
         end
         if (bus.in_valid && bus.in_ready) sb.push_back('{pick(m_ptr, bus.channel_enable), bus.in_data});
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks += 5;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
      if (bus.out_valid !== 4'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0000", bus.out_valid); end
      if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h, required 00", bus.out_data); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
      if (bus.select !== 2'd0) begin n_fail++; $display("FAIL rst_select: got %0d, required 0", bus.select); end
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b, required 1", bus.in_ready); end
   endtask
   task automatic test_back_to_back();
      logic [7:0] d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      int ch [5] = '{0, 1, 2, 3, 0};
      bus.out_ready = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++;
         if (k == 0) begin
            if (bus.out_valid !== 4'b0) begin n_fail++; $display("FAIL b2b_pre_valid: got %b, required 0000", bus.out_valid); end
         end else if (bus.out_valid !== 4'(1 << ch[k-1]) || bus.out_data !== d[k-1]) begin
            n_fail++;
            $display("FAIL b2b_word%0d: got %b/%h, required %b/%h", k - 1, bus.out_valid, bus.out_data, 4'(1 << ch[k-1]), d[k-1]);
         end
         bus.in_valid = 1'b1;
         bus.in_data = d[k];
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d: got %b, required 1", k, bus.in_ready); end
      end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h55) begin
         n_fail++;
         $display("FAIL b2b_word4: got %b/%h, required 0001/55", bus.out_valid, bus.out_data);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 4'b0 || bus.select !== 2'd1) begin
         n_fail++;
         $display("FAIL b2b_drain: got %b sel %0d, required 0000 sel 1", bus.out_valid, bus.select);
      end
   endtask
   task automatic test_stall();
      bus.out_ready = 4'b1011;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h66;
      tick();
      bus.in_data = 8'hA5;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_pass_ready: got %b, required 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (bus.out_valid !== 4'b0100 || bus.out_data !== 8'hA5 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.select !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got v=%b d=%h rdy=%b busy=%b sel=%0d, required 0100 A5 0 1 2",
                     k, bus.out_valid, bus.out_data, bus.in_ready, bus.busy, bus.select);
         end
         tick();
      end
      bus.out_ready = 4'b1111;
      tick();
      n_checks++;
      if (bus.out_valid !== 4'b0 || bus.select !== 2'd3 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b sel=%0d busy=%b, required 0000 3 0", bus.out_valid, bus.select, bus.busy);
      end
   endtask
   task automatic test_flush();
      bus.out_ready = 4'b1111;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h70;
      tick();
      bus.in_data = 8'h71;
      tick();
      bus.in_data = 8'h72;
      tick();
      bus.out_ready = 4'b0000;
      bus.in_data = 8'h73;
      bus.flush = 1'b1;
      #1;
      n_checks += 2;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 0", bus.in_ready); end
      if (bus.out_valid !== 4'b0010) begin n_fail++; $display("FAIL flush_pre_valid: got %b, required 0010", bus.out_valid); end
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b0 || bus.busy !== 1'b0 || bus.select !== 2'd0) begin
         n_fail++;
         $display("FAIL flush_after: got v=%b busy=%b sel=%0d, required 0000 0 0", bus.out_valid, bus.busy, bus.select);
      end
      bus.out_ready = 4'b1111;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h74;
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h74) begin
         n_fail++;
         $display("FAIL flush_next: got %b/%h, required 0001/74", bus.out_valid, bus.out_data);
      end
      tick();
   endtask
   task automatic test_async_reset();
      bus.out_ready = 4'b0000;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h88;
      tick();
      bus.in_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.out_valid !== 4'b0010) begin n_fail++; $display("FAIL areset_pre: got %b, required 0010", bus.out_valid); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 4'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0 || bus.select !== 2'd0 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_now: got v=%b d=%h busy=%b sel=%0d rdy=%b, required 0000 00 0 0 0",
                  bus.out_valid, bus.out_data, bus.busy, bus.select, bus.in_ready);
      end
      tick();
      rst = 1'b0;
      bus.out_ready = 4'b1111;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h99;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_rel_ready: got %b, required 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h99) begin
         n_fail++;
         $display("FAIL areset_first: got %b/%h, required 0001/99", bus.out_valid, bus.out_data);
      end
      tick();
   endtask
   task automatic test_mask();
      logic [7:0] d [3] = '{8'h01, 8'h02, 8'h03};
`ifdef DEMUX_DISPATCHER_MASK_EN
      int ch [3] = '{1, 3, 1};
`else
      int ch [3] = '{0, 1, 2};
`endif
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.channel_enable = 4'b1010;
      bus.out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 4'(1 << ch[k-1]) || bus.out_data !== d[k-1]) begin
               n_fail++;
               $display("FAIL mask_word%0d: got %b/%h, required %b/%h", k - 1, bus.out_valid, bus.out_data, 4'(1 << ch[k-1]), d[k-1]);
            end
         end
         bus.in_valid = (k < 3);
         bus.in_data = (k < 3) ? d[k] : 8'h00;
      end
      tick();
`ifdef DEMUX_DISPATCHER_MASK_EN
      bus.channel_enable = 4'b0000;
      bus.in_valid = 1'b1;
      bus.in_data = 8'hEE;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_none%0d: got rdy=%b busy=%b, required 0 0", k, bus.in_ready, bus.busy);
         end
         tick();
      end
      bus.in_valid = 1'b0;
      bus.channel_enable = 4'b1111;
`endif
   endtask
   initial begin
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      bus.out_ready = 4'b1111;
      bus.channel_enable = 4'b1111;
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush();
      test_async_reset();
      test_mask();
      repeat (3) tick();
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d words undelivered, required 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
